// File: rtl/conv_pkg.sv
// Shared definitions for the striped-BRAM convolution blocks: loader states
// and the stripe-depth mapping used by both the loader and the controller.
package conv_pkg;

  typedef enum logic [1:0] {
    LOAD,
    START,
    BUSY
  } loader_state_t;

  // Words per bank: one stripe row of IMG_W words for every FILTER_L image rows.
  function automatic int stripe_depth(input int img_h, input int filter_l, input int img_w);
    return ((img_h + filter_l - 1) / filter_l) * img_w;
  endfunction

endpackage

// File: rtl/conv_stripe_addr_gen.sv
// Raster-order w/bank/stripe counter for row-striped image banks; produces
// the one-hot bank, the bank word address and a last-pixel flag.
module conv_stripe_addr_gen #(
  parameter int IMG_W     = 16,
  parameter int IMG_H     = 16,
  parameter int FILTER_L  = 3,
  parameter int STRIPE_AW = 6
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 clear_i,
  input  logic                 step_i,
  output logic [FILTER_L-1:0]  bank_oh_o,
  output logic [STRIPE_AW-1:0] addr_o,
  output logic                 last_o
);

  localparam int NSTRIPE = (IMG_H + FILTER_L - 1) / FILTER_L;
  localparam int WW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int HW = (IMG_H > 1) ? $clog2(IMG_H) : 1;
  localparam int BW = (FILTER_L > 1) ? $clog2(FILTER_L) : 1;
  localparam int SW = (NSTRIPE > 1) ? $clog2(NSTRIPE) : 1;

  logic [WW-1:0] w_q, w_d;
  logic [HW-1:0] h_q, h_d;
  logic [BW-1:0] bank_q, bank_d;
  logic [SW-1:0] stripe_q, stripe_d;
  logic          row_end;

  assign row_end = (w_q == WW'(IMG_W - 1));
  assign last_o  = row_end && (h_q == HW'(IMG_H - 1));

  // Constant multiply only; the bank/stripe pair replaces a divide by FILTER_L.
  assign addr_o = STRIPE_AW'(32'(stripe_q) * 32'(IMG_W) + 32'(w_q));

  for (genvar gi = 0; gi < FILTER_L; gi++) begin : g_bank_oh
    assign bank_oh_o[gi] = (bank_q == BW'(gi));
  end

  always_comb begin
    w_d      = w_q;
    h_d      = h_q;
    bank_d   = bank_q;
    stripe_d = stripe_q;
    if (clear_i) begin
      w_d      = '0;
      h_d      = '0;
      bank_d   = '0;
      stripe_d = '0;
    end else if (step_i) begin
      if (last_o) begin
        // Wrap to origin so no counter ever runs past its range.
        w_d      = '0;
        h_d      = '0;
        bank_d   = '0;
        stripe_d = '0;
      end else if (row_end) begin
        w_d = '0;
        h_d = h_q + 1'b1;
        if (bank_q == BW'(FILTER_L - 1)) begin
          bank_d   = '0;
          stripe_d = stripe_q + 1'b1;
        end else begin
          bank_d = bank_q + 1'b1;
        end
      end else begin
        w_d = w_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      w_q      <= '0;
      h_q      <= '0;
      bank_q   <= '0;
      stripe_q <= '0;
    end else begin
      w_q      <= w_d;
      h_q      <= h_d;
      bank_q   <= bank_d;
      stripe_q <= stripe_d;
    end
  end

endmodule

// File: rtl/conv_img_stripe_loader.sv
// Streams one raster-order image into the row-striped BRAM banks, then hands
// it to the convolution controller and waits for its completion pulse.
module conv_img_stripe_loader
  import conv_pkg::*;
#(
  parameter int DATA_WIDTH   = 12,
  parameter int IMG_W        = 16,
  parameter int IMG_H        = 16,
  parameter int IMG_D        = 4,
  parameter int FILTER_L     = 3,
  parameter int STRIPE_DEPTH = stripe_depth(IMG_H, FILTER_L, IMG_W),
  parameter int STRIPE_AW    = $clog2(STRIPE_DEPTH)
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        in_val,
  output logic                        in_rdy,
  input  logic [DATA_WIDTH*IMG_D-1:0] in_data,
  output logic [FILTER_L-1:0]         img_wren,
  output logic [STRIPE_AW-1:0]        img_wraddr,
  output logic [DATA_WIDTH*IMG_D-1:0] img_wrdata,
  output logic                        conv_val,
  input  logic                        conv_rdy,
  input  logic                        conv_done,
  output logic                        busy
);

  loader_state_t state_q, state_d;

  logic                        accept;
  logic                        clear;
  logic                        last_px;
  logic [FILTER_L-1:0]         bank_oh;
  logic [STRIPE_AW-1:0]        addr;
  logic                        seen_q, seen_d;
  logic [FILTER_L-1:0]         wren_q, wren_d;
  logic [STRIPE_AW-1:0]        wraddr_q, wraddr_d;
  logic [DATA_WIDTH*IMG_D-1:0] wrdata_q, wrdata_d;

  assign in_rdy   = (state_q == LOAD);
  assign conv_val = (state_q == START);
  assign accept   = in_val && in_rdy;
  assign clear    = (state_q == BUSY) && conv_done;
  assign busy     = (state_q != LOAD) || seen_q;

  assign img_wren   = wren_q;
  assign img_wraddr = wraddr_q;
  assign img_wrdata = wrdata_q;

  conv_stripe_addr_gen #(
    .IMG_W    (IMG_W),
    .IMG_H    (IMG_H),
    .FILTER_L (FILTER_L),
    .STRIPE_AW(STRIPE_AW)
  ) u_addr_gen (
    .clk      (clk),
    .reset    (reset),
    .clear_i  (clear),
    .step_i   (accept),
    .bank_oh_o(bank_oh),
    .addr_o   (addr),
    .last_o   (last_px)
  );

  always_comb begin
    state_d  = state_q;
    seen_d   = seen_q;
    wren_d   = '0;
    wraddr_d = wraddr_q;
    wrdata_d = wrdata_q;
    if (accept) begin
      wren_d   = bank_oh;
      wraddr_d = addr;
      wrdata_d = in_data;
      seen_d   = 1'b1;
    end
    unique case (state_q)
      LOAD:    if (accept && last_px) state_d = START;
      START:   if (conv_rdy) state_d = BUSY;
      BUSY:    if (conv_done) begin
                 state_d = LOAD;
                 seen_d  = 1'b0;
               end
      default: state_d = LOAD;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= LOAD;
      seen_q   <= 1'b0;
      wren_q   <= '0;
      wraddr_q <= '0;
      wrdata_q <= '0;
    end else begin
      state_q  <= state_d;
      seen_q   <= seen_d;
      wren_q   <= wren_d;
      wraddr_q <= wraddr_d;
      wrdata_q <= wrdata_d;
    end
  end

endmodule

// File: tb/tb_conv_img_stripe_loader.sv
// Directed bench for conv_img_stripe_loader with a 4x5 image, 3 banks, 2 channels.
module tb_conv_img_stripe_loader;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_val;
  logic        in_rdy;
  logic [23:0] in_data;
  logic [2:0]  img_wren;
  logic [2:0]  img_wraddr;
  logic [23:0] img_wrdata;
  logic        conv_val;
  logic        conv_rdy;
  logic        conv_done;
  logic        busy;

  int n_cmp = 0;
  int n_err = 0;
  int n_writes = 0;
  int gaps[8] = '{0, 2, 0, 1, 0, 0, 3, 1};

  conv_img_stripe_loader #(
    .DATA_WIDTH(12),
    .IMG_W     (4),
    .IMG_H     (5),
    .IMG_D     (2),
    .FILTER_L  (3)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .in_val    (in_val),
    .in_rdy    (in_rdy),
    .in_data   (in_data),
    .img_wren  (img_wren),
    .img_wraddr(img_wraddr),
    .img_wrdata(img_wrdata),
    .conv_val  (conv_val),
    .conv_rdy  (conv_rdy),
    .conv_done (conv_done),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Drive inputs, pass one rising edge, then sample 1 time unit later.
  task automatic cyc(input logic v, input logic [23:0] d);
    in_val  = v;
    in_data = d;
    @(posedge clk);
    #1;
    if (img_wren != 3'b000) n_writes++;
  endtask

  task automatic stream(input int n_beats, input bit use_gaps, input int tag);
    for (int i = 0; i < n_beats; i++) begin
      int w;
      int h;
      logic [23:0] d;
      w = i % 4;
      h = i / 4;
      if (use_gaps) begin
        for (int g = 0; g < gaps[i % 8]; g++) begin
          cyc(1'b0, 24'hFFFFFF);
          chk("idle_wren", 32'(img_wren), 0);
          chk("idle_rdy", 32'(in_rdy), 1);
        end
      end
      d = {12'(tag * 16 + h), 12'(w * 7 + 1)};
      cyc(1'b1, d);
      $display("img%0d write w=%0d h=%0d wren=%b addr=%0d data=%h conv_val=%b",
               tag, w, h, img_wren, img_wraddr, img_wrdata, conv_val);
      chk("wr_bank", 32'(img_wren), 32'(1) << (h % 3));
      chk("wr_addr", 32'(img_wraddr), 32'((h / 3) * 4 + w));
      chk("wr_data", 32'(img_wrdata), 32'(d));
      if (i == 0) begin
        chk("first_bank", 32'(img_wren), 32'h1);
        chk("first_addr", 32'(img_wraddr), 32'h0);
      end
      if (tag == 1 && w == 2 && h == 4) begin
        chk("px_2_4_wren", 32'(img_wren), 32'b010);
        chk("px_2_4_addr", 32'(img_wraddr), 6);
      end
      if (tag == 1 && w == 3 && h == 2) begin
        chk("px_3_2_wren", 32'(img_wren), 32'b100);
        chk("px_3_2_addr", 32'(img_wraddr), 3);
      end
      if (i == 19) begin
        chk("last_rdy", 32'(in_rdy), 0);
        chk("last_conv_val", 32'(conv_val), 1);
      end else begin
        chk("load_rdy", 32'(in_rdy), 1);
        chk("load_conv_val", 32'(conv_val), 0);
        chk("load_busy", 32'(busy), 1);
      end
    end
  endtask

  initial begin
    reset     = 1'b1;
    in_val    = 1'b0;
    in_data   = '0;
    conv_rdy  = 1'b0;
    conv_done = 1'b0;
    cyc(1'b0, 24'h0);
    cyc(1'b0, 24'h0);
    reset = 1'b0;
    $display("reset: wren=%b addr=%0d rdy=%b conv_val=%b busy=%b",
             img_wren, img_wraddr, in_rdy, conv_val, busy);
    chk("rst_wren", 32'(img_wren), 0);
    chk("rst_addr", 32'(img_wraddr), 0);
    chk("rst_data", 32'(img_wrdata), 0);
    chk("rst_conv_val", 32'(conv_val), 0);
    chk("rst_rdy", 32'(in_rdy), 1);
    chk("rst_busy", 32'(busy), 0);

    // Image 1: in_val held high, no gaps.
    n_writes = 0;
    stream(20, 1'b0, 1);
    chk("write_count", 32'(n_writes), 20);

    // START with conv_rdy low; in_val stays high and must be ignored.
    for (int k = 0; k < 5; k++) begin
      conv_done = (k == 2);
      cyc(1'b1, 24'h123456);
      $display("start wait %0d: conv_val=%b rdy=%b wren=%b", k, conv_val, in_rdy, img_wren);
      chk("start_conv_val", 32'(conv_val), 1);
      chk("start_rdy", 32'(in_rdy), 0);
      chk("start_wren", 32'(img_wren), 0);
    end
    conv_done = 1'b0;
    conv_rdy  = 1'b1;
    cyc(1'b1, 24'h123456);
    conv_rdy = 1'b0;
    $display("handshake: conv_val=%b rdy=%b busy=%b", conv_val, in_rdy, busy);
    chk("busy_conv_val", 32'(conv_val), 0);
    chk("busy_rdy", 32'(in_rdy), 0);
    chk("busy_busy", 32'(busy), 1);
    for (int k = 0; k < 2; k++) begin
      cyc(1'b1, 24'h654321);
      chk("busy_hold_rdy", 32'(in_rdy), 0);
      chk("busy_hold_wren", 32'(img_wren), 0);
    end
    conv_done = 1'b1;
    cyc(1'b1, 24'h654321);
    conv_done = 1'b0;
    $display("done: rdy=%b busy=%b wren=%b", in_rdy, busy, img_wren);
    chk("done_rdy", 32'(in_rdy), 1);
    chk("done_busy", 32'(busy), 0);
    chk("done_wren", 32'(img_wren), 0);

    // Image 2 with in_val bubbles; conv_rdy high in LOAD must not raise conv_val.
    conv_rdy = 1'b1;
    n_writes = 0;
    stream(20, 1'b1, 2);
    chk("write_count2", 32'(n_writes), 20);
    cyc(1'b0, 24'h0);
    conv_rdy = 1'b0;
    chk("img2_busy_conv_val", 32'(conv_val), 0);
    conv_done = 1'b1;
    cyc(1'b0, 24'h0);
    conv_done = 1'b0;
    chk("img2_done_rdy", 32'(in_rdy), 1);

    // Image 3 aborted by reset after 7 beats.
    stream(7, 1'b0, 3);
    reset = 1'b1;
    cyc(1'b1, 24'hAAAAAA);
    reset = 1'b0;
    $display("mid reset: wren=%b rdy=%b busy=%b", img_wren, in_rdy, busy);
    chk("midrst_wren", 32'(img_wren), 0);
    chk("midrst_rdy", 32'(in_rdy), 1);
    chk("midrst_busy", 32'(busy), 0);
    stream(3, 1'b0, 4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/conv_img_stripe_loader.md
# conv_img_stripe_loader

Upstream feeder for the striped-BRAM shift-register convolution controller. Accepts one image as a raster-order valid/ready stream of pixels, each beat carrying all channels. Writes each pixel into the row-striped image BRAMs: row h goes to bank h % FILTER_L at word (h / FILTER_L) * IMG_W + w. After the last pixel it issues the start handshake to the convolution controller, then holds off the next image until that controller reports completion.

## Interface
Parameters:
- DATA_WIDTH, 12, bits per channel sample
- IMG_W, 16, image width
- IMG_H, 16, image height
- IMG_D, 4, channels per beat (one BRAM per channel per bank)
- FILTER_L, 3, filter length; equals the number of row stripes/banks
- STRIPE_DEPTH, ((IMG_H+FILTER_L-1)/FILTER_L)*IMG_W, words per bank (derived)
- STRIPE_AW, $clog2(STRIPE_DEPTH), bank address width (derived)

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high
- in_val  in  1  pixel beat valid
- in_rdy  out  1  loader accepts a beat
- in_data  in  DATA_WIDTH*IMG_D  pixel, channel c at bits [c*DATA_WIDTH +: DATA_WIDTH]
- img_wren  out  FILTER_L  one-hot bank write enable
- img_wraddr  out  STRIPE_AW  write address, shared by all banks
- img_wrdata  out  DATA_WIDTH*IMG_D  write data, shared by all banks
- conv_val  out  1  image resident; start convolution
- conv_rdy  in  1  convolution controller idle/ready
- conv_done  in  1  single-cycle pulse: convolution of the current image finished
- busy  out  1  high in any state other than LOAD with zero pixels accepted

## Operation
- Three states, kept in a register:
  - LOAD: in_rdy = 1. On each in_val && in_rdy, write the pixel; advance w. When w = IMG_W-1: w wraps to 0, h advances, bank advances mod FILTER_L, and stripe row advances when bank wraps. The beat with w = IMG_W-1 and h = IMG_H-1 moves to START.
  - START: in_rdy = 0, conv_val = 1. conv_val holds until conv_rdy is sampled high in the same cycle; that handshake moves to BUSY.
  - BUSY: in_rdy = 0, conv_val = 0. conv_done moves to LOAD and clears all counters: w = h = bank = stripe = 0.
- Address is built without a divider, using an incremental bank/stripe counter pair: img_wraddr = stripe*IMG_W + w. The multiply is by a constant. The result is truncated to STRIPE_AW bits and never exceeds STRIPE_DEPTH-1.
- img_wren is one-hot at bit `bank`, and is all zeros when no write occurs.
- A conv_done that arrives in LOAD or START is ignored.
- A conv_rdy that arrives outside START is ignored.
- in_data is ignored whenever in_rdy = 0.
- If IMG_H % FILTER_L != 0, the trailing stripe words of the unused banks are left unwritten.

## Timing
- Write latency is one cycle. A beat accepted at the edge ending cycle t drives img_wren, img_wraddr and img_wrdata during cycle t+1. All three are registered.
- The last pixel's write and conv_val both first appear in cycle t+1. The BRAM write commits at the end of t+1, so the controller's first read (no earlier than t+2) sees the complete image.
- in_rdy is decoded directly from state. It drops in the cycle after the last beat is accepted, so no extra beat is ever taken.
- Back-to-back images: the minimum gap is 1 cycle after conv_done, which is the first LOAD cycle with in_rdy = 1.
- Throughput in LOAD is one pixel per cycle. Bubbles on in_val are allowed and produce an all-zero img_wren in the following cycle.
- Reset values: state = LOAD, all counters 0, img_wren = 0, img_wraddr = 0, img_wrdata = 0, conv_val = 0, in_rdy = 1 from the first cycle after reset. Reset asserted mid-image discards the partial image; no further writes occur after the reset edge.

## Structure
- conv_pkg holds the state enum `loader_state_t {LOAD, START, BUSY}` and the STRIPE_DEPTH helper function, so the convolution controller uses the identical stripe mapping.
- One sub-module, conv_stripe_addr_gen: a w / bank / stripe counter with clear and step inputs, producing bank (one-hot), address and a last-pixel flag. It is reusable by a future result-drain block.
- The top level contains the FSM and the output registers.

## Test plan
All scenarios use IMG_W=4, IMG_H=5, FILTER_L=3, IMG_D=2, so STRIPE_DEPTH=8 and STRIPE_AW=3.
- Full image streamed with in_val held at 1:
  - pixel (w=2,h=4) gives img_wren=3'b010 and img_wraddr=6;
  - pixel (w=3,h=2) gives img_wren=3'b100 and img_wraddr=3;
  - exactly 20 writes occur, and conv_val rises in the cycle of the 20th write.
- Random in_val gaps: every write matches the scoreboard address/bank map; an idle cycle produces img_wren=0; in_rdy is high throughout LOAD.
- conv_rdy held low for 5 cycles in START: conv_val stays high and in_rdy stays 0; when conv_rdy=1 the state moves to BUSY and conv_val=0 the next cycle.
- conv_done pulsed in START, then in BUSY: the first pulse is ignored; after the second, in_rdy=1 and the next image's first write goes to bank 0 at address 0.
- Reset after 7 beats: the next cycle shows img_wren=0 and in_rdy=1, and the restarted image begins at img_wraddr=0 in bank 0.
